// File: rtl/uart_prog_loader_pkg.sv
// rtl/uart_prog_loader_pkg.sv - shared types, widths and address map for the UART program loader
// Contents:
//   rx_state_t   RX FSM states (IDLE, START, DATA, STOP)
//   ADR_W        programming-port address width (15)
//   WORD_W       programming-port data width (32)
//   REGION_BIT   address bit selecting IMEM (0) or DMEM (1)
//   map_adr()    word counter -> programming-port address
package loader_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int ADR_W      = 15;
  localparam int WORD_W     = 32;
  localparam int REGION_BIT = 14;

  // Words below imem_words land in IMEM at their own index; the rest land in
  // DMEM, re-based to index 0.
  function automatic logic [ADR_W-1:0] map_adr(input logic [15:0] cnt,
                                                input logic [15:0] imem_words);
    logic [15:0] off;
    off = cnt - imem_words;
    if (cnt < imem_words) map_adr = {1'b0, cnt[13:0]};
    else                  map_adr = {1'b1, off[13:0]};
  endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// rtl/uart_prog_loader_if.sv - programming-port bundle between loader and fetch stage / data memory
// Signals:
//   upg_wen_o   one-cycle write strobe
//   upg_adr_o   [14]=0 IMEM / 1 DMEM, [13:0] word index
//   upg_dat_o   word being written
//   upg_done_o  load complete, sticky until reset
// Modports: master (loader drives), slave (memories / CPU observe)
import loader_pkg::*;

interface uart_prog_loader_if;
  logic              upg_wen_o;
  logic [ADR_W-1:0]  upg_adr_o;
  logic [WORD_W-1:0] upg_dat_o;
  logic              upg_done_o;

  modport master (output upg_wen_o, output upg_adr_o, output upg_dat_o, output upg_done_o);
  modport slave  (input  upg_wen_o, input  upg_adr_o, input  upg_dat_o, input  upg_done_o);
endinterface

// File: rtl/uart_prog_loader_rx.sv
// rtl/uart_prog_loader_rx.sv - UART byte receiver: 2-FF synchroniser, start/data/stop FSM
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   rx_i         raw RX line, idle high, asynchronous to clk
//   byte_o       last good byte, held until the next one
//   byte_vld     one-cycle pulse when byte_o is fresh
//   frame_err    one-cycle pulse when a stop bit sampled 0 (byte dropped)
import loader_pkg::*;

module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_vld,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state;
  logic             rx_meta, rx_s, rx_d;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_d      <= 1'b1;
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_o    <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx_i;
      rx_s      <= rx_meta;
      rx_d      <= rx_s;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          // Edge rather than level, so a line held low after a bad stop bit
          // is not mistaken for a new start bit.
          if (rx_d && !rx_s) state <= START;
        end
        START: begin
          if (clk_cnt == HALF) begin
            clk_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;  // high at mid-start = glitch
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == FULL) begin
            clk_cnt <= '0;
            shreg   <= {rx_s, shreg[7:1]};  // LSB arrives first
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == FULL) begin
            clk_cnt <= '0;
            state   <= IDLE;
            if (rx_s) begin
              byte_o   <= shreg;
              byte_vld <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART program loader: packs LE bytes into words, writes IMEM then DMEM
// Ports:
//   clk, reset    loader clock, asynchronous active-high reset
//   rx_i          UART RX line
//   upg_clk_o     clk passthrough for the programming port
//   upg           programming-port bundle (master): wen/adr/dat/done
//   busy_o        first byte received and load not yet done
//   frame_err_o   sticky: some byte had a 0 stop bit
//   csum_err_o    sticky checksum mismatch (tied 0 without the checksum option)
// Build option: LOADER_CHECKSUM_EN adds a 4-byte sum trailer after the image.
import loader_pkg::*;

module uart_prog_loader #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int IMEM_WORDS = 16384,
  parameter int DMEM_WORDS = 16384
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_i,
  output logic                upg_clk_o,
  uart_prog_loader_if.master  upg,
  output logic                busy_o,
  output logic                frame_err_o,
  output logic                csum_err_o
);

  localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [15:0] IMEM_N       = 16'(IMEM_WORDS);
  localparam logic [15:0] TOTAL_N      = 16'(IMEM_WORDS + DMEM_WORDS);

  logic [7:0]        rx_byte;
  logic              byte_vld, frame_err_p;
  logic [1:0]        byte_idx;
  logic [23:0]       byte_buf;
  logic [15:0]       word_cnt;
  logic [WORD_W-1:0] word;
  logic              image_done;
  logic              byte_take;

  assign upg_clk_o  = clk;
  assign word       = {rx_byte, byte_buf};
  assign image_done = (word_cnt == TOTAL_N);
  assign byte_take  = byte_vld && !upg.upg_done_o;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx_i      (rx_i),
    .byte_o    (rx_byte),
    .byte_vld  (byte_vld),
    .frame_err (frame_err_p)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
`else
  assign csum_err_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upg.upg_wen_o  <= 1'b0;
      upg.upg_adr_o  <= '0;
      upg.upg_dat_o  <= '0;
      upg.upg_done_o <= 1'b0;
      busy_o         <= 1'b0;
      frame_err_o    <= 1'b0;
      byte_idx       <= '0;
      byte_buf       <= '0;
      word_cnt       <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum            <= '0;
      csum_err_o     <= 1'b0;
`endif
    end else begin
      upg.upg_wen_o <= 1'b0;
      if (frame_err_p) frame_err_o <= 1'b1;

      if (byte_take) begin
        busy_o   <= 1'b1;
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0: byte_buf[7:0]   <= rx_byte;
          2'd1: byte_buf[15:8]  <= rx_byte;
          2'd2: byte_buf[23:16] <= rx_byte;
          default: begin
            if (!image_done) begin
              upg.upg_wen_o <= 1'b1;
              upg.upg_adr_o <= map_adr(word_cnt, IMEM_N);
              upg.upg_dat_o <= word;
              word_cnt      <= word_cnt + 16'd1;
`ifdef LOADER_CHECKSUM_EN
              sum           <= sum + word;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            else begin
              // Trailer word: compare against the running sum, then finish.
              upg.upg_done_o <= 1'b1;
              busy_o         <= 1'b0;
              if (word != sum) csum_err_o <= 1'b1;
            end
`endif
          end
        endcase
      end

`ifndef LOADER_CHECKSUM_EN
      // Strobe just issued was the last image word.
      if (upg.upg_wen_o && image_done) begin
        upg.upg_done_o <= 1'b1;
        busy_o         <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - self-checking bench for uart_prog_loader (randomized bytes, word/address model)
module tb_uart_prog_loader;

  localparam int CPB  = 16;
  localparam int IMEM = 4;
  localparam int DMEM = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_i = 1'b1;
  logic upg_clk_o, busy_o, frame_err_o, csum_err_o;

  uart_prog_loader_if upg();

  uart_prog_loader #(
    .CLK_HZ(1_600_000), .BAUD(100_000), .IMEM_WORDS(IMEM), .DMEM_WORDS(DMEM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_i        (rx_i),
    .upg_clk_o   (upg_clk_o),
    .upg         (upg.master),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o),
    .csum_err_o  (csum_err_o)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  logic [14:0] st_adr[$];
  logic [31:0] st_dat[$];
  int          st_cyc[$];
  bit          done_seen;
  int          done_cyc;
  logic [7:0]  img[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (upg.upg_wen_o) begin
        st_adr.push_back(upg.upg_adr_o);
        st_dat.push_back(upg.upg_dat_o);
        st_cyc.push_back(cyc);
      end
      if (upg.upg_done_o && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
    end
  end

  // Reference model: word k is bytes 4k..4k+3 little-endian; first IMEM words
  // go to IMEM index k, the rest to DMEM index k-IMEM.
  function automatic logic [31:0] exp_word(input int k);
    exp_word = {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]};
  endfunction

  function automatic logic [14:0] exp_adr(input int k);
    if (k < IMEM) exp_adr = 15'(k);
    else          exp_adr = 15'(16384 + k - IMEM);
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_i  = 1'b1;
    st_adr.delete();
    st_dat.delete();
    st_cyc.delete();
    img.delete();
    done_seen = 1'b0;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_clks(CPB);
    end
    rx_i = stop_bit;
    wait_clks(CPB);
    rx_i = 1'b1;
    wait_clks(CPB);
  endtask

  task automatic send_random(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      img.push_back(b);
      send_byte(b, 1'b1);
    end
  endtask

  // Full image plus, with the checksum option, the sum trailer (+1 if bad).
  task automatic send_image(input bit bad_sum);
    logic [31:0] s;
    send_random(4 * (IMEM + DMEM));
`ifdef LOADER_CHECKSUM_EN
    s = 32'd0;
    for (int k = 0; k < IMEM + DMEM; k++) s = s + exp_word(k);
    if (bad_sum) s = s + 32'd1;
    for (int i = 0; i < 4; i++) send_byte(s[8*i +: 8], 1'b1);
`else
    s = {31'd0, bad_sum};
`endif
    wait_clks(40);
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (upg.upg_wen_o !== 1'b0) $display("FAIL reset_wen got %b want 0", upg.upg_wen_o); else pass_cnt++;
    total_cnt++; if (upg.upg_adr_o !== 15'd0) $display("FAIL reset_adr got %h want 0", upg.upg_adr_o); else pass_cnt++;
    total_cnt++; if (upg.upg_dat_o !== 32'd0) $display("FAIL reset_dat got %h want 0", upg.upg_dat_o); else pass_cnt++;
    total_cnt++; if (upg.upg_done_o !== 1'b0) $display("FAIL reset_done got %b want 0", upg.upg_done_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else pass_cnt++;
    total_cnt++; if (frame_err_o !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err_o); else pass_cnt++;
    total_cnt++; if (csum_err_o !== 1'b0) $display("FAIL reset_csum_err got %b want 0", csum_err_o); else pass_cnt++;
  endtask

  task automatic test_single_word();
    logic [7:0] seq [4];
    seq = '{8'h78, 8'h56, 8'h34, 8'h12};
    do_reset();
    foreach (seq[i]) send_byte(seq[i], 1'b1);
    wait_clks(40);
    total_cnt++; if (st_adr.size() !== 1) $display("FAIL single_count got %0d want 1", st_adr.size()); else pass_cnt++;
    if (st_adr.size() >= 1) begin
      total_cnt++; if (st_adr[0] !== 15'h0000) $display("FAIL single_adr got %h want 0000", st_adr[0]); else pass_cnt++;
      total_cnt++; if (st_dat[0] !== 32'h12345678) $display("FAIL single_dat got %h want 12345678", st_dat[0]); else pass_cnt++;
    end
    total_cnt++; if (upg.upg_dat_o !== 32'h12345678) $display("FAIL single_dat_hold got %h want 12345678", upg.upg_dat_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b1) $display("FAIL single_busy got %b want 1", busy_o); else pass_cnt++;
    total_cnt++; if (upg.upg_done_o !== 1'b0) $display("FAIL single_done got %b want 0", upg.upg_done_o); else pass_cnt++;
  endtask

  task automatic test_full_load();
    do_reset();
    send_image(1'b0);
    total_cnt++; if (st_adr.size() !== IMEM + DMEM) $display("FAIL full_count got %0d want %0d", st_adr.size(), IMEM + DMEM); else pass_cnt++;
    for (int k = 0; k < IMEM + DMEM && k < st_adr.size(); k++) begin
      total_cnt++; if (st_adr[k] !== exp_adr(k)) $display("FAIL full_adr[%0d] got %h want %h", k, st_adr[k], exp_adr(k)); else pass_cnt++;
      total_cnt++; if (st_dat[k] !== exp_word(k)) $display("FAIL full_dat[%0d] got %h want %h", k, st_dat[k], exp_word(k)); else pass_cnt++;
    end
    total_cnt++; if (upg.upg_done_o !== 1'b1) $display("FAIL full_done got %b want 1", upg.upg_done_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL full_busy got %b want 0", busy_o); else pass_cnt++;
    total_cnt++; if (csum_err_o !== 1'b0) $display("FAIL full_csum_err got %b want 0", csum_err_o); else pass_cnt++;
`ifndef LOADER_CHECKSUM_EN
    if (st_cyc.size() == IMEM + DMEM) begin
      total_cnt++;
      if (!done_seen || done_cyc != st_cyc[IMEM + DMEM - 1] + 1)
        $display("FAIL full_done_timing got cycle %0d want %0d", done_cyc, st_cyc[IMEM + DMEM - 1] + 1);
      else pass_cnt++;
    end
`endif
  endtask

  task automatic test_ignore_after_done();
    // Continues from a completed load.
    for (int i = 0; i < 30; i++) send_byte(8'($urandom), 1'b1);
    wait_clks(40);
    total_cnt++; if (st_adr.size() !== IMEM + DMEM) $display("FAIL ignore_count got %0d want %0d", st_adr.size(), IMEM + DMEM); else pass_cnt++;
    total_cnt++; if (upg.upg_done_o !== 1'b1) $display("FAIL ignore_done got %b want 1", upg.upg_done_o); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    do_reset();
    send_byte(8'($urandom), 1'b0);
    wait_clks(20);
    total_cnt++; if (frame_err_o !== 1'b1) $display("FAIL frame_err got %b want 1", frame_err_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL frame_busy got %b want 0", busy_o); else pass_cnt++;
    send_random(4);
    wait_clks(40);
    total_cnt++; if (st_adr.size() !== 1) $display("FAIL frame_count got %0d want 1", st_adr.size()); else pass_cnt++;
    if (st_adr.size() >= 1) begin
      total_cnt++; if (st_adr[0] !== exp_adr(0)) $display("FAIL frame_adr got %h want %h", st_adr[0], exp_adr(0)); else pass_cnt++;
      total_cnt++; if (st_dat[0] !== exp_word(0)) $display("FAIL frame_dat got %h want %h", st_dat[0], exp_word(0)); else pass_cnt++;
    end
    total_cnt++; if (frame_err_o !== 1'b1) $display("FAIL frame_sticky got %b want 1", frame_err_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    send_random(6);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    total_cnt++; if (upg.upg_adr_o !== 15'd0) $display("FAIL midrst_adr got %h want 0", upg.upg_adr_o); else pass_cnt++;
    total_cnt++; if (upg.upg_dat_o !== 32'd0) $display("FAIL midrst_dat got %h want 0", upg.upg_dat_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy_o); else pass_cnt++;
    do_reset();
    send_random(4);
    wait_clks(40);
    total_cnt++; if (st_adr.size() !== 1) $display("FAIL midrst_count got %0d want 1", st_adr.size()); else pass_cnt++;
    if (st_adr.size() >= 1) begin
      total_cnt++; if (st_adr[0] !== 15'h0000) $display("FAIL midrst_reload_adr got %h want 0000", st_adr[0]); else pass_cnt++;
      total_cnt++; if (st_dat[0] !== exp_word(0)) $display("FAIL midrst_reload_dat got %h want %h", st_dat[0], exp_word(0)); else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    do_reset();
    rx_i = 1'b0;
    wait_clks(CPB / 4);
    rx_i = 1'b1;
    wait_clks(3 * CPB);
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL glitch_busy got %b want 0", busy_o); else pass_cnt++;
    send_random(4);
    wait_clks(40);
    total_cnt++; if (st_adr.size() !== 1) $display("FAIL glitch_count got %0d want 1", st_adr.size()); else pass_cnt++;
    if (st_dat.size() >= 1) begin
      total_cnt++; if (st_dat[0] !== exp_word(0)) $display("FAIL glitch_dat got %h want %h", st_dat[0], exp_word(0)); else pass_cnt++;
    end
  endtask

  task automatic test_checksum();
`ifdef LOADER_CHECKSUM_EN
    do_reset();
    send_image(1'b1);
    total_cnt++; if (upg.upg_done_o !== 1'b1) $display("FAIL csum_bad_done got %b want 1", upg.upg_done_o); else pass_cnt++;
    total_cnt++; if (csum_err_o !== 1'b1) $display("FAIL csum_bad_err got %b want 1", csum_err_o); else pass_cnt++;
    total_cnt++; if (st_adr.size() !== IMEM + DMEM) $display("FAIL csum_bad_count got %0d want %0d", st_adr.size(), IMEM + DMEM); else pass_cnt++;
`else
    total_cnt++; if (csum_err_o !== 1'b0) $display("FAIL csum_tied got %b want 0", csum_err_o); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_load();
    test_ignore_after_done();
    test_frame_err();
    test_reset_mid_load();
    test_glitch();
    test_checksum();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
